// File: rtl/vector_sweep.sv
// Sweeps all eight {a,b,c} vectors through a downstream cell, holds each for SETTLE_CYC
// cycles, then checks x/y. Optional macro SWEEP_FAIL_CAPTURE_EN adds first-failure capture.
module vector_sweep #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt
`ifdef SWEEP_FAIL_CAPTURE_EN
    ,
    output logic [2:0] fail_vec,
    output logic       fail_vld
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [2:0] vec_idx_q, vec_idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch;
`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [2:0] fail_vec_q, fail_vec_d;
    logic       fail_vld_q, fail_vld_d;
`endif

    // Golden cell: x = ~c ^ (a | b), y = a & b, evaluated on the vector being driven.
    always_comb begin
        mismatch = (x != (~vec_idx_q[0] ^ (vec_idx_q[2] | vec_idx_q[1]))) ||
                   (y != (vec_idx_q[2] & vec_idx_q[1]));
    end

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
`ifdef SWEEP_FAIL_CAPTURE_EN
        fail_vec_d = fail_vec_q;
        fail_vld_d = fail_vld_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    vec_idx_d = 3'd0;
                    cnt_d     = SETTLE_LD;
                    err_d     = 4'd0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
`ifdef SWEEP_FAIL_CAPTURE_EN
                    fail_vec_d = 3'd0;
                    fail_vld_d = 1'b0;
`endif
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Count saturates at 8; one increment per vector even if both outputs differ.
                if (mismatch && (err_q != 4'd8)) begin
                    err_d = err_q + 4'd1;
                end
`ifdef SWEEP_FAIL_CAPTURE_EN
                if (mismatch && !fail_vld_q) begin
                    fail_vec_d = vec_idx_q;
                    fail_vld_d = 1'b1;
                end
`endif
                if (vec_idx_q != 3'd7) begin
                    vec_idx_d = vec_idx_q + 3'd1;
                    cnt_d     = SETTLE_LD;
                    state_d   = SETTLE;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_idx_q <= 3'd0;
            cnt_q     <= 4'd0;
            err_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef SWEEP_FAIL_CAPTURE_EN
            fail_vec_q <= 3'd0;
            fail_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
`ifdef SWEEP_FAIL_CAPTURE_EN
            fail_vec_q <= fail_vec_d;
            fail_vld_q <= fail_vld_d;
`endif
        end
    end

    // Stimulus comes straight from the index register, so DONE naturally holds 1,1,1.
    assign a       = vec_idx_q[2];
    assign b       = vec_idx_q[1];
    assign c       = vec_idx_q[0];
    assign vec_idx = vec_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef SWEEP_FAIL_CAPTURE_EN
    assign fail_vec = fail_vec_q;
    assign fail_vld = fail_vld_q;
`endif

endmodule

// File: tb/tb_vector_sweep.sv
// Bench for vector_sweep: two instances (SETTLE_CYC=1 and 3) driving a cell with
// injectable per-vector faults on x and y.
module tb_vector_sweep;

    logic       clk;
    logic       rst;
    logic       st   [2];
    logic       oa   [2];
    logic       ob   [2];
    logic       oc   [2];
    logic       cx   [2];
    logic       cy   [2];
    logic [2:0] vidx [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [3:0] errc [2];
    logic [7:0] xm   [2];
    logic [7:0] ym   [2];
`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [2:0] fvec [2];
    logic       fvld [2];
`endif

    int checks = 0;
    int errors = 0;

    vector_sweep #(.SETTLE_CYC(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]),
        .a(oa[0]), .b(ob[0]), .c(oc[0]), .x(cx[0]), .y(cy[0]),
        .vec_idx(vidx[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(errc[0])
`ifdef SWEEP_FAIL_CAPTURE_EN
        , .fail_vec(fvec[0]), .fail_vld(fvld[0])
`endif
    );

    vector_sweep #(.SETTLE_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]),
        .a(oa[1]), .b(ob[1]), .c(oc[1]), .x(cx[1]), .y(cy[1]),
        .vec_idx(vidx[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(errc[1])
`ifdef SWEEP_FAIL_CAPTURE_EN
        , .fail_vec(fvec[1]), .fail_vld(fvld[1])
`endif
    );

    // Cell under test: correct logic with a per-vector flip mask on each output.
    assign cx[0] = (~oc[0] ^ (oa[0] | ob[0])) ^ xm[0][{oa[0], ob[0], oc[0]}];
    assign cy[0] = (oa[0] & ob[0]) ^ ym[0][{oa[0], ob[0], oc[0]}];
    assign cx[1] = (~oc[1] ^ (oa[1] | ob[1])) ^ xm[1][{oa[1], ob[1], oc[1]}];
    assign cy[1] = (oa[1] & ob[1]) ^ ym[1][{oa[1], ob[1], oc[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [7:0] xmv;
        logic [7:0] ymv;
        int         e_err;
        bit         e_pass;
        int         e_fv;
        bit         e_fvld;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int i);
        chk("reset_outputs", {busy[i], done[i], pass[i], vidx[i], oa[i], ob[i], oc[i], errc[i]}, 32'd0);
`ifdef SWEEP_FAIL_CAPTURE_EN
        chk("reset_fail", {fvec[i], fvld[i]}, 32'd0);
`endif
    endtask

    // Full sweep from IDLE/DONE; hold keeps start high throughout and checks the restart.
    task automatic sweep(input int i, input logic [7:0] xmv, input logic [7:0] ymv,
                         input int e_err, input bit e_pass, input int e_fv, input bit e_fvld,
                         input bit hold);
        int s   = (i == 0) ? 1 : 3;
        int len = 8 * (s + 1);
        xm[i] = xmv;
        ym[i] = ymv;
        st[i] = 1'b1;
        tick();
        if (!hold) st[i] = 1'b0;
        chk("start_edge", {busy[i], done[i], pass[i], vidx[i], errc[i]}, {1'b1, 1'b0, 1'b0, 3'd0, 4'd0});
`ifdef SWEEP_FAIL_CAPTURE_EN
        chk("start_fail_clear", {29'd0, fvld[i], 2'd0}, 32'd0);
`endif
        for (int k = 1; k < len; k++) begin
            tick();
            chk("step", {busy[i], done[i], vidx[i], oa[i], ob[i], oc[i]},
                {1'b1, 1'b0, 3'(k / (s + 1)), 3'(k / (s + 1))});
        end
        tick();
        chk("done_rise", {busy[i], done[i], vidx[i], oa[i], ob[i], oc[i]}, {1'b0, 1'b1, 3'd7, 3'b111});
        chk("err_cnt", {28'd0, errc[i]}, e_err);
        chk("pass", {31'd0, pass[i]}, {31'd0, e_pass});
`ifdef SWEEP_FAIL_CAPTURE_EN
        chk("fail_vld", {31'd0, fvld[i]}, {31'd0, e_fvld});
        if (e_fvld) chk("fail_vec", {29'd0, fvec[i]}, e_fv);
`endif
        tick();
        if (hold) begin
            st[i] = 1'b0;
            chk("restart", {busy[i], done[i], pass[i], vidx[i], errc[i]}, {1'b1, 1'b0, 1'b0, 3'd0, 4'd0});
        end else begin
            chk("done_persist", {done[i], pass[i], errc[i], vidx[i]}, {1'b1, e_pass, 4'(e_err), 3'd7});
        end
    endtask

    initial begin
        int e_err;
        int e_fv;
        bit e_fvld;
        int idx;
        logic [7:0] rx;
        logic [7:0] ry;
        bit seen_done;
        bit seen_busy;
        bit hit;

        tbl[0] = '{0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b0};
        tbl[1] = '{0, 8'h00, 8'hC0, 2, 1'b0, 6, 1'b1};   // y stuck at 0
        tbl[2] = '{0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b0};   // restart after failing sweep
        tbl[3] = '{1, 8'hFF, 8'h00, 8, 1'b0, 0, 1'b1};   // x inverted, SETTLE_CYC=3
        tbl[4] = '{0, 8'h24, 8'h81, 4, 1'b0, 0, 1'b1};
        tbl[5] = '{1, 8'h10, 8'h10, 1, 1'b0, 4, 1'b1};   // both outputs wrong on one vector

        rst = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0;
        xm[0] = 8'h00; xm[1] = 8'h00; ym[0] = 8'h00; ym[1] = 8'h00;
        tick(); tick(); tick();
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;
        tick();
        chk_reset_state(0);

        for (int t = 0; t < 6; t++) begin
            sweep(tbl[t].inst, tbl[t].xmv, tbl[t].ymv, tbl[t].e_err, tbl[t].e_pass,
                  tbl[t].e_fv, tbl[t].e_fvld, 1'b0);
        end

        // Random fault masks scored by counting faulty vectors directly.
        for (int r = 0; r < 8; r++) begin
            idx = int'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rx = 8'h00;
                ry = 8'h00;
            end
            e_err = 0; e_fv = 0; e_fvld = 1'b0;
            for (int v = 0; v < 8; v++) begin
                if (rx[v] || ry[v]) begin
                    if (!e_fvld) e_fv = v;
                    e_fvld = 1'b1;
                    e_err++;
                end
            end
            sweep(idx, rx, ry, e_err, (e_err == 0), e_fv, e_fvld, 1'b0);
        end

        // start held high for the whole sweep, then restart from DONE.
        sweep(0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b0, 1'b1);

        // Reset together with start while vector 4 is driven.
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            if (vidx[0] == 3'd4) hit = 1'b1;
            else tick();
        end
        chk("reach_vec4", {31'd0, hit}, 32'd1);
        st[0] = 1'b1;
        rst = 1'b1;
        tick();
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;
        st[0] = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done[0]) seen_done = 1'b1;
            if (busy[0]) seen_busy = 1'b1;
        end
        chk("no_done_after_abort", {30'd0, seen_done, seen_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sweep.md
VECTOR_SWEEP -- requirements
Module: vector_sweep

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 1, giving the cycles each vector is held before its response is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, sweep request, sampled in IDLE or DONE only.
REQ-005 The block SHALL have ports a, b, c, output, 1 each, registered stimulus to the downstream logic cell; {a,b,c} = vec_idx, with a as MSB.
REQ-006 The block SHALL have ports x, y, input, 1 each, the cell's responses to a, b, c.
REQ-007 The block SHALL have port vec_idx, output, 3, the index of the vector currently driven.
REQ-008 The block SHALL have port busy, output, 1, high in SETTLE and CHECK.
REQ-009 The block SHALL have port done, output, 1, high in DONE.
REQ-010 The block SHALL have port pass, output, 1, high in DONE when err_cnt == 0.
REQ-011 The block SHALL have port err_cnt, output, 4, the mismatch count of the current or last sweep (0..8).

Function
REQ-012 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-013 IDLE or DONE with start=1 SHALL go to SETTLE and, on the same edge, clear vec_idx and err_cnt and load the settle counter with SETTLE_CYC.
REQ-014 SETTLE SHALL decrement the settle counter each cycle and go to CHECK in the cycle after the counter reaches 1, so every vector is held exactly SETTLE_CYC cycles before its CHECK cycle.
REQ-015 CHECK SHALL compare x against golden ~c ^ (a | b) and y against golden a & b, and increment err_cnt by 1 if either differs.
REQ-016 CHECK with vec_idx < 7 SHALL increment vec_idx, reload the settle counter and go to SETTLE.
REQ-017 CHECK with vec_idx == 7 SHALL go to DONE and hold a, b, c at 1,1,1.
REQ-018 err_cnt SHALL NOT wrap; it has 8 checks at most, so its maximum is 8.
REQ-019 Latency: done SHALL rise exactly 8*(SETTLE_CYC+1) edges after the edge that samples start.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 DONE SHALL persist, with err_cnt and pass frozen, until rst or a new start.
REQ-022 start=1 in DONE SHALL restart the sweep per REQ-013; done and pass drop on that same edge.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE and set a, b, c, vec_idx, busy, done, pass and err_cnt to 0, plus fail_vec when present.
REQ-024 Reset SHALL dominate start in the same cycle.
REQ-025 Reset during a sweep SHALL abort it without completing; no done pulse follows.

Configuration
REQ-026 With macro SWEEP_FAIL_CAPTURE_EN defined, the block SHALL add port fail_vec, output, 3, and fail_vld, output, 1.
REQ-027 With SWEEP_FAIL_CAPTURE_EN defined, the first mismatching vec_idx of a sweep SHALL be latched into fail_vec and fail_vld set to 1.
REQ-028 With SWEEP_FAIL_CAPTURE_EN defined, fail_vec and fail_vld SHALL be cleared by rst or by a sweep start.
REQ-029 With SWEEP_FAIL_CAPTURE_EN defined, later mismatches in the same sweep SHALL NOT alter fail_vec.
REQ-030 Without SWEEP_FAIL_CAPTURE_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Correct cell connected, SETTLE_CYC=1, one-cycle start pulse -> vec_idx steps 0..7 every 2 cycles, done at edge 16, err_cnt=0, pass=1.
REQ-032 y stuck at 0 -> only vectors 6 and 7 fail, err_cnt=2, pass=0; with the macro defined, fail_vec=6 and fail_vld=1.
REQ-033 x inverted, SETTLE_CYC=3 -> err_cnt=8, done at edge 32 after start.
REQ-034 start held high through the whole sweep -> no restart while busy; sweep restarts on the first edge in DONE, done high for exactly one cycle.
REQ-035 rst asserted while vec_idx=4 and start=1 -> next cycle IDLE, all outputs 0, done never asserts.
REQ-036 start=1 after a failing sweep -> err_cnt and fail_vld cleared on that edge, new sweep passes with a correct cell.
